cmt: RTL and testbench

Commit stage sitting directly downstream of the reorder buffer. Each cycle it inspects up to `2^CONFIG_P_COMMIT_WIDTH` head entries presented by the ROB and selects the in-order prefix that may retire. It returns that count to the ROB as `cmt_pop_size`, releases the physical registers of retired instructions, and issues branch-predictor updates and store-commit requests. When a retiring entry carries the flush tag, it raises a one-cycle pipeline `flush` plus a redirect target.

---
 rtl/cmt_pkg.sv | 17 +
 rtl/cmt_sel.sv | 55 +++++
 rtl/cmt.sv | 125 ++++++++++++
 tb/tb_cmt.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmt_pkg.sv
// Shared widths, field positions and FSM encodings for the commit stage.
package cmt_pkg;

    localparam int NCPU_EPU_IOPW  = 4;
    localparam int NCPU_LSU_IOPW  = 4;
    localparam int NCPU_LSU_STORE = 1;
    localparam int BPU_UPD_W      = 16;
    localparam int BPU_UPD_VLD    = 0;
    localparam int PC_W           = 62;
    localparam int NCPU_PRF_AW    = 6;

    typedef enum logic {
        CMT_S_RUN   = 1'b0,
        CMT_S_FLUSH = 1'b1
    } cmt_state_e;

endpackage

// File: rtl/cmt_sel.sv
// Combinational selector: finds the in-order prefix of ROB head slots that may retire.
module cmt_sel
    import cmt_pkg::*;
#(
    parameter int P  = 1,
    parameter int CW = 1 << P
) (
    input  logic [CW-1:0]               valid_i,
    input  logic [CW-1:0]               fls_i,
    input  logic [CW*NCPU_EPU_IOPW-1:0] epu_opc_i,
    input  logic [CW*NCPU_LSU_IOPW-1:0] lsu_opc_i,
    input  logic                        stb_ready_i,
    output logic [CW-1:0]               retire_o,
    output logic [P:0]                  cnt_o,
    output logic                        stb_o
);

    logic unused_lsu;
    assign unused_lsu = ^lsu_opc_i;

    always_comb begin
        logic ok;
        logic is_ser;
        logic is_st;
        logic ser_seen;
        logic st_seen;
        logic fls_seen;
        ok       = 1'b1;
        is_ser   = 1'b0;
        is_st    = 1'b0;
        ser_seen = 1'b0;
        st_seen  = 1'b0;
        fls_seen = 1'b0;
        retire_o = '0;
        cnt_o    = '0;
        stb_o    = 1'b0;
        for (int k = 0; k < CW; k++) begin
            is_ser = |epu_opc_i[k*NCPU_EPU_IOPW +: NCPU_EPU_IOPW];
            is_st  = lsu_opc_i[k*NCPU_LSU_IOPW + NCPU_LSU_STORE];
            // Once any slot is blocked, every younger slot is blocked too.
            if (!valid_i[k] || fls_seen || ser_seen || (is_ser && k != 0) ||
                (is_st && (st_seen || !stb_ready_i)))
                ok = 1'b0;
            if (ok) begin
                retire_o[k] = 1'b1;
                cnt_o       = cnt_o + (P+1)'(1);
                stb_o       = stb_o | is_st;
            end
            ser_seen = ser_seen | is_ser;
            st_seen  = st_seen | is_st;
            fls_seen = fls_seen | fls_i[k];
        end
    end

endmodule

// File: rtl/cmt.sv
// Commit stage: retires the eligible ROB head prefix, frees pregs, updates BPU, raises flush.
module cmt
    import cmt_pkg::*;
#(
    parameter  int CONFIG_P_COMMIT_WIDTH = 1,
    parameter  int CONFIG_DW             = 64,
    parameter  int CONFIG_AW             = 64,
    localparam int CW                    = 1 << CONFIG_P_COMMIT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CW-1:0]                 cmt_valid,
    input  logic [CW*NCPU_EPU_IOPW-1:0]   cmt_epu_opc_bus,
    input  logic [CW*NCPU_LSU_IOPW-1:0]   cmt_lsu_opc_bus,
    input  logic [CW*BPU_UPD_W-1:0]       cmt_bpu_upd,
    input  logic [CW*PC_W-1:0]            cmt_pc,
    input  logic [CW-1:0]                 cmt_prd_we,
    input  logic [CW*NCPU_PRF_AW-1:0]     cmt_pfree,
    input  logic [CW-1:0]                 cmt_fls,
    input  logic [CW*CONFIG_DW-1:0]       cmt_opera,
    input  logic [CW*CONFIG_DW-1:0]       cmt_operb,
    input  logic                          stb_ready,
    output logic [CONFIG_P_COMMIT_WIDTH:0] cmt_pop_size,
    output logic                          stb_commit,
    output logic                          flush,
    output logic [CONFIG_AW-1:0]          flush_tgt,
    output logic [CW-1:0]                 fl_free_we,
    output logic [CW*NCPU_PRF_AW-1:0]     fl_free_preg,
    output logic [CW-1:0]                 bpu_upd_we,
    output logic [CW*BPU_UPD_W-1:0]       bpu_upd,
    output logic [63:0]                   retired_cnt
);

    cmt_state_e                    state_q, state_d;
    logic [CW-1:0]                 sel_mask;
    logic [CONFIG_P_COMMIT_WIDTH:0] sel_cnt;
    logic                          sel_stb;
    logic                          run;
    logic [CW-1:0]                 retire;
    logic                          fls_hit;

    logic                          flush_q;
    logic [CONFIG_AW-1:0]          flush_tgt_q, flush_tgt_d;
    logic [CW-1:0]                 free_we_q, free_we_d;
    logic [CW*NCPU_PRF_AW-1:0]     free_preg_q;
    logic [CW-1:0]                 bpu_we_q, bpu_we_d;
    logic [CW*BPU_UPD_W-1:0]       bpu_upd_q;
    logic [63:0]                   cnt_q;

    logic unused_ok;
    assign unused_ok = ^{cmt_pc, cmt_operb, cmt_opera};

    cmt_sel #(
        .P  (CONFIG_P_COMMIT_WIDTH),
        .CW (CW)
    ) u_sel (
        .valid_i     (cmt_valid),
        .fls_i       (cmt_fls),
        .epu_opc_i   (cmt_epu_opc_bus),
        .lsu_opc_i   (cmt_lsu_opc_bus),
        .stb_ready_i (stb_ready),
        .retire_o    (sel_mask),
        .cnt_o       (sel_cnt),
        .stb_o       (sel_stb)
    );

    // Gating on rst keeps the ROB from advancing while the stage is held in reset.
    assign run          = rst && (state_q == CMT_S_RUN);
    assign retire       = run ? sel_mask : '0;
    assign fls_hit      = |(retire & cmt_fls);
    assign cmt_pop_size = run ? sel_cnt : '0;
    assign stb_commit   = run & sel_stb;

    always_comb begin
        state_d = state_q;
        case (state_q)
            CMT_S_RUN:   if (fls_hit) state_d = CMT_S_FLUSH;
            CMT_S_FLUSH: state_d = CMT_S_RUN;
            default:     state_d = CMT_S_RUN;
        endcase
    end

    always_comb begin
        flush_tgt_d = flush_tgt_q;
        free_we_d   = '0;
        bpu_we_d    = '0;
        for (int k = 0; k < CW; k++) begin
            free_we_d[k] = retire[k] & cmt_prd_we[k];
            bpu_we_d[k]  = retire[k] & cmt_bpu_upd[k*BPU_UPD_W + BPU_UPD_VLD];
            if (retire[k] && cmt_fls[k])
                flush_tgt_d = cmt_opera[k*CONFIG_DW +: CONFIG_AW];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= CMT_S_RUN;
            flush_q     <= 1'b0;
            flush_tgt_q <= '0;
            free_we_q   <= '0;
            free_preg_q <= '0;
            bpu_we_q    <= '0;
            bpu_upd_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            flush_q     <= fls_hit;
            flush_tgt_q <= flush_tgt_d;
            free_we_q   <= free_we_d;
            free_preg_q <= cmt_pfree;
            bpu_we_q    <= bpu_we_d;
            bpu_upd_q   <= cmt_bpu_upd;
            cnt_q       <= cnt_q + 64'(cmt_pop_size);
        end
    end

    assign flush        = flush_q;
    assign flush_tgt    = flush_tgt_q;
    assign fl_free_we   = free_we_q;
    assign fl_free_preg = free_preg_q;
    assign bpu_upd_we   = bpu_we_q;
    assign bpu_upd      = bpu_upd_q;
    assign retired_cnt  = cnt_q;

endmodule

// File: tb/tb_cmt.sv
// Bench for cmt: per-cycle compare against a behavioural retirement model plus literal spot checks.
module tb_cmt;
    import cmt_pkg::*;

    localparam int P  = 1;
    localparam int CW = 2;
    localparam int DW = 64;
    localparam int AW = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [CW-1:0]               cmt_valid;
    logic [CW*NCPU_EPU_IOPW-1:0] cmt_epu_opc_bus;
    logic [CW*NCPU_LSU_IOPW-1:0] cmt_lsu_opc_bus;
    logic [CW*BPU_UPD_W-1:0]     cmt_bpu_upd;
    logic [CW*PC_W-1:0]          cmt_pc;
    logic [CW-1:0]               cmt_prd_we;
    logic [CW*NCPU_PRF_AW-1:0]   cmt_pfree;
    logic [CW-1:0]               cmt_fls;
    logic [CW*DW-1:0]            cmt_opera;
    logic [CW*DW-1:0]            cmt_operb;
    logic                        stb_ready;

    logic [P:0]                  cmt_pop_size;
    logic                        stb_commit;
    logic                        flush;
    logic [AW-1:0]               flush_tgt;
    logic [CW-1:0]               fl_free_we;
    logic [CW*NCPU_PRF_AW-1:0]   fl_free_preg;
    logic [CW-1:0]               bpu_upd_we;
    logic [CW*BPU_UPD_W-1:0]     bpu_upd;
    logic [63:0]                 retired_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cmt #(
        .CONFIG_P_COMMIT_WIDTH (P),
        .CONFIG_DW             (DW),
        .CONFIG_AW             (AW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cmt_valid       (cmt_valid),
        .cmt_epu_opc_bus (cmt_epu_opc_bus),
        .cmt_lsu_opc_bus (cmt_lsu_opc_bus),
        .cmt_bpu_upd     (cmt_bpu_upd),
        .cmt_pc          (cmt_pc),
        .cmt_prd_we      (cmt_prd_we),
        .cmt_pfree       (cmt_pfree),
        .cmt_fls         (cmt_fls),
        .cmt_opera       (cmt_opera),
        .cmt_operb       (cmt_operb),
        .stb_ready       (stb_ready),
        .cmt_pop_size    (cmt_pop_size),
        .stb_commit      (stb_commit),
        .flush           (flush),
        .flush_tgt       (flush_tgt),
        .fl_free_we      (fl_free_we),
        .fl_free_preg    (fl_free_preg),
        .bpu_upd_we      (bpu_upd_we),
        .bpu_upd         (bpu_upd),
        .retired_cnt     (retired_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic                      m_fs   = 1'b0;
    logic                      m_flush = 1'b0;
    logic [AW-1:0]             m_tgt  = '0;
    logic [CW-1:0]             m_fwe  = '0;
    logic [CW-1:0]             m_bwe  = '0;
    logic [CW*NCPU_PRF_AW-1:0] m_preg = '0;
    logic [CW*BPU_UPD_W-1:0]   m_bupd = '0;
    logic [63:0]               m_cnt  = '0;

    function automatic logic is_store(input int k);
        return cmt_lsu_opc_bus[k*NCPU_LSU_IOPW + NCPU_LSU_STORE];
    endfunction

    function automatic logic is_ser(input int k);
        return cmt_epu_opc_bus[k*NCPU_EPU_IOPW +: NCPU_EPU_IOPW] != 0;
    endfunction

    // Walk the head slots; the first slot that breaks a retirement rule ends the prefix.
    function automatic int model_pop();
        int n;
        int older_stores;
        n = 0;
        older_stores = 0;
        if (!rst || m_fs) return 0;
        for (int k = 0; k < CW; k++) begin
            if (!cmt_valid[k]) break;
            if (k > 0 && cmt_fls[k-1]) break;
            if (k > 0 && (is_ser(k) || is_ser(k-1))) break;
            if (is_store(k) && (!stb_ready || older_stores > 0)) break;
            if (is_store(k)) older_stores++;
            n++;
        end
        return n;
    endfunction

    function automatic logic model_stb();
        int n;
        logic s;
        n = model_pop();
        s = 1'b0;
        for (int k = 0; k < CW; k++)
            if (k < n && is_store(k)) s = 1'b1;
        return s;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_fs = 1'b0; m_flush = 1'b0; m_tgt = '0; m_fwe = '0; m_bwe = '0;
            m_preg = '0; m_bupd = '0; m_cnt = '0;
        end else begin : upd
            int n;
            n = model_pop();
            m_flush = 1'b0;
            for (int k = 0; k < CW; k++) begin
                m_fwe[k] = (k < n) && cmt_prd_we[k];
                m_bwe[k] = (k < n) && cmt_bpu_upd[k*BPU_UPD_W + BPU_UPD_VLD];
            end
            if (n > 0 && cmt_fls[n-1]) begin
                m_flush = 1'b1;
                m_tgt   = cmt_opera[(n-1)*DW +: AW];
            end
            m_fs   = m_flush;
            m_preg = cmt_pfree;
            m_bupd = cmt_bpu_upd;
            m_cnt  = m_cnt + 64'(n);
        end
    end

    always @(negedge clk) begin
        chk("pop",        64'(cmt_pop_size), 64'(model_pop()));
        chk("stb_commit", 64'(stb_commit),   64'(model_stb()));
        chk("flush",      64'(flush),        64'(m_flush));
        chk("flush_tgt",  64'(flush_tgt),    64'(m_tgt));
        chk("free_we",    64'(fl_free_we),   64'(m_fwe));
        chk("free_preg",  64'(fl_free_preg), 64'(m_preg));
        chk("bpu_we",     64'(bpu_upd_we),   64'(m_bwe));
        chk("bpu_upd",    64'(bpu_upd),      64'(m_bupd));
        chk("retired",    retired_cnt,       m_cnt);
    end

    // ---------------- stimulus ----------------
    typedef struct packed {
        logic [1:0]  valid;
        logic [1:0]  fls;
        logic [7:0]  epu;
        logic [7:0]  lsu;
        logic [31:0] bupd;
        logic        rdy;
        logic [1:0]  exp_pop;
    } vec_t;

    vec_t vecs [7];

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cmt_valid = '0; cmt_fls = '0; cmt_epu_opc_bus = '0; cmt_lsu_opc_bus = '0;
        cmt_prd_we = '0; cmt_bpu_upd = '0; stb_ready = 1'b1;
    endtask

    initial begin
        vecs[0] = '{2'b11, 2'b10, 8'h00, 8'h00, 32'h0, 1'b1, 2'd2};
        vecs[1] = '{2'b11, 2'b01, 8'h03, 8'h00, 32'h0, 1'b1, 2'd1};
        vecs[2] = '{2'b11, 2'b00, 8'h00, 8'h20, 32'h0, 1'b0, 2'd1};
        vecs[3] = '{2'b11, 2'b00, 8'h00, 8'h20, 32'h0, 1'b1, 2'd2};
        vecs[4] = '{2'b10, 2'b00, 8'h00, 8'h00, 32'h0, 1'b1, 2'd0};
        vecs[5] = '{2'b11, 2'b00, 8'h00, 8'h00, 32'hab0100c4, 1'b1, 2'd2};
        vecs[6] = '{2'b11, 2'b00, 8'h00, 8'h02, 32'h0, 1'b0, 2'd0};

        idle();
        cmt_pc    = {62'h100, 62'h104};
        cmt_pfree = '0;
        cmt_opera = '0;
        cmt_operb = '0;
        cmt_valid = 2'b11;

        // Held in reset with both entries valid.
        cyc(); cyc();
        #1;
        chk("rst_pop", 64'(cmt_pop_size), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_cnt", retired_cnt, 64'd0);

        cyc();
        rst = 1'b1;
        #1 chk("rel_pop", 64'(cmt_pop_size), 64'd2);
        cyc();
        idle();
        #1 chk("rel_cnt", retired_cnt, 64'd2);

        // Dual retire with one destination write.
        cyc();
        cmt_valid = 2'b11; cmt_prd_we = 2'b01; cmt_pfree = {6'd7, 6'd5};
        #1 chk("dual_pop", 64'(cmt_pop_size), 64'd2);
        cyc();
        idle();
        #1;
        chk("dual_free_we", 64'(fl_free_we), 64'h1);
        chk("dual_preg0", 64'(fl_free_preg[5:0]), 64'd5);
        chk("dual_cnt", retired_cnt, 64'd4);

        // Flush in slot 0.
        cyc();
        cmt_valid = 2'b11; cmt_fls = 2'b01; cmt_opera = {64'h2222, 64'h1000};
        #1 chk("fls_pop", 64'(cmt_pop_size), 64'd1);
        cyc();
        cmt_fls = 2'b00;
        #1;
        chk("fls_flush", 64'(flush), 64'd1);
        chk("fls_tgt", flush_tgt, 64'h1000);
        chk("fls_pop0", 64'(cmt_pop_size), 64'd0);
        cyc();
        #1;
        chk("fls_drop", 64'(flush), 64'd0);
        chk("fls_resume", 64'(cmt_pop_size), 64'd2);
        cyc();
        idle();

        // Store back-pressure.
        cyc();
        cmt_valid = 2'b11; cmt_lsu_opc_bus = 8'h22; stb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stb_stall", 64'(cmt_pop_size), 64'd0);
            cyc();
        end
        stb_ready = 1'b1;
        #1;
        chk("stb_pop", 64'(cmt_pop_size), 64'd1);
        chk("stb_commit1", 64'(stb_commit), 64'd1);
        cyc();
        #1 chk("stb_next", 64'(cmt_pop_size), 64'd1);
        cyc();
        idle();

        // Serializing op in slot 1, then in slot 0 after the ROB shifts.
        cyc();
        cmt_valid = 2'b11; cmt_epu_opc_bus = 8'h10;
        #1 chk("ser_pop1", 64'(cmt_pop_size), 64'd1);
        cyc();
        cmt_epu_opc_bus = 8'h01;
        #1 chk("ser_pop2", 64'(cmt_pop_size), 64'd1);
        cyc();
        idle();

        // Directed vector table, each followed by an idle cycle.
        for (int v = 0; v < 7; v++) begin
            cyc();
            cmt_valid = vecs[v].valid; cmt_fls = vecs[v].fls;
            cmt_epu_opc_bus = vecs[v].epu; cmt_lsu_opc_bus = vecs[v].lsu;
            cmt_bpu_upd = vecs[v].bupd; stb_ready = vecs[v].rdy;
            cmt_prd_we = 2'b11; cmt_pfree = 12'(6'(v) * 7);
            cmt_opera = {64'h3000 + 64'(v), 64'h4000 + 64'(v)};
            #1 chk("vec_pop", 64'(cmt_pop_size), 64'(vecs[v].exp_pop));
            cyc();
            idle();
        end

        // Reset asserted while flush is high.
        cyc();
        cmt_valid = 2'b01; cmt_fls = 2'b01; cmt_opera = {64'h0, 64'h2000};
        cyc();
        idle();
        #1 chk("rf_flush_hi", 64'(flush), 64'd1);
        #1 rst = 1'b0;
        #1;
        chk("rf_flush_lo", 64'(flush), 64'd0);
        chk("rf_tgt", flush_tgt, 64'd0);
        chk("rf_cnt", retired_cnt, 64'd0);
        cyc();
        rst = 1'b1;
        cmt_valid = 2'b01;
        #1 chk("rf_pop", 64'(cmt_pop_size), 64'd1);
        cyc();
        idle();
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
